// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from instruction memory over a
// req/ready handshake, issues each instruction and waits for execution to finish.
module instr_fetch_unit #(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          ps,
    input  logic [PC_WIDTH-1:0] pc_in,
    input  logic [63:0]         constant,
    input  logic                exec_done,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_ready,
    output logic [31:0]         instruction,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                fetch_fault
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        EXEC,
        FAULT
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [CW-1:0]       waitCount;
    logic [PC_WIDTH-1:0] pcNext;
    logic [63:0]         constShifted;

    // The PC only moves on the EXEC->FETCH edge, so driving the address straight
    // from it keeps the address stable for the whole request.
    assign imem_addr    = pc;
    assign pc_plus4     = pc + PC_WIDTH'(4);
    assign constShifted = constant << 2;

    always_comb begin
        pcNext = pc;
        case (ps)
            2'b00:   pcNext = pc;
            2'b01:   pcNext = pc_plus4;
            2'b10:   pcNext = pc_in & {{(PC_WIDTH-2){1'b1}}, 2'b00};
            default: pcNext = pc + constShifted[PC_WIDTH-1:0];
        endcase
    end

    always_comb begin
        stateNext   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_fault = 1'b0;
        case (state)
            IDLE: stateNext = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    stateNext = ISSUE;
                end else if (waitCount == CW'(TIMEOUT - 1)) begin
                    stateNext = FAULT;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                stateNext   = EXEC;
            end
            EXEC: begin
                if (exec_done) begin
                    stateNext = FETCH;
                end
            end
            FAULT: fetch_fault = 1'b1;
            default: stateNext = IDLE;
        endcase
    end

    // exec_done is only honoured in EXEC, so a held-high done advances the PC once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instruction <= '0;
            waitCount   <= '0;
        end else begin
            state <= stateNext;
            if (state == FETCH) begin
                if (imem_ready) begin
                    instruction <= imem_rdata;
                    waitCount   <= '0;
                end else begin
                    waitCount <= waitCount + CW'(1);
                end
            end
            if (state == EXEC && exec_done) begin
                pc <= pcNext;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a memory responder pushes each returned
// word onto a scoreboard queue, popped and compared when instr_valid pulses.
module tb_instr_fetch_unit;

    localparam int PW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    ps;
    logic [PW-1:0] pc_in;
    logic [63:0]   constant;
    logic          exec_done;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          imem_ready;
    logic [31:0]   instruction;
    logic          instr_valid;
    logic [PW-1:0] pc;
    logic [PW-1:0] pc_plus4;
    logic          fetch_fault;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] expQ[$];
    bit          memEnable = 1'b0;
    int          memDelay  = 0;
    int          waitCnt   = 0;

    bit            obsSeen;
    int            obsCycles;
    int            obsReq;
    bit            obsAddrMoved;
    logic [PW-1:0] obsAddr;
    logic [31:0]   obsInstr;
    logic [PW-1:0] obsPc;
    logic [PW-1:0] obsPlus4;
    logic          obsFault;

    typedef struct {
        logic [1:0]  nps;
        logic [63:0] npcin;
        logic [63:0] nconst;
        logic [63:0] expAddr;
        int          expGap;
    } step_t;

    instr_fetch_unit #(
        .PC_WIDTH(PW),
        .RESET_PC(64'h0),
        .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps(ps),
        .pc_in(pc_in),
        .constant(constant),
        .exec_done(exec_done),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [63:0] a);
        if (a == 64'h0) return 32'h91019004;
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0003;
    endfunction

    // Memory model: answers after memDelay request cycles, driven on the falling edge.
    always @(negedge clk) begin
        if (memEnable) begin
            if (imem_req && !rst) begin
                if (waitCnt >= memDelay) begin
                    imem_ready = 1'b1;
                    imem_rdata = memData(imem_addr);
                    expQ.push_back(imem_rdata);
                    waitCnt = 0;
                end else begin
                    imem_ready = 1'b0;
                    waitCnt++;
                end
            end else begin
                imem_ready = 1'b0;
                waitCnt    = 0;
            end
        end
    end

    // Waits (bounded) for the next instr_valid pulse, recording what the fetch looked like,
    // then presents the PC-select inputs that instruction will complete with.
    task automatic applyStimulus(input logic [1:0] nPs, input logic [63:0] nPcIn,
                                 input logic [63:0] nConst);
        obsSeen = 1'b0; obsCycles = 0; obsReq = 0; obsAddrMoved = 1'b0; obsAddr = '0;
        for (int i = 0; i < 40 && !obsSeen; i++) begin
            @(negedge clk);
            obsCycles++;
            if (imem_req) begin
                if (obsReq == 0) obsAddr = imem_addr;
                else if (imem_addr !== obsAddr) obsAddrMoved = 1'b1;
                obsReq++;
            end
            if (instr_valid) begin
                obsSeen  = 1'b1;
                obsInstr = instruction;
                obsPc    = pc;
                obsPlus4 = pc_plus4;
                obsFault = fetch_fault;
                ps       = nPs;
                pc_in    = nPcIn;
                constant = nConst;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ps = 2'b01; pc_in = '0; constant = '0; exec_done = 1'b1;
        imem_ready = 1'b0; imem_rdata = '0; memDelay = 0; memEnable = 1'b1;
        repeat (3) @(negedge clk);
        checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL reset_req: got %b want 0", imem_req); else passCount++;
        checkCount++; if (imem_addr !== 64'h0) $display("[TB] FAIL reset_addr: got %h want 0", imem_addr); else passCount++;
        checkCount++; if (pc !== 64'h0) $display("[TB] FAIL reset_pc: got %h want 0", pc); else passCount++;
        checkCount++; if (pc_plus4 !== 64'h4) $display("[TB] FAIL reset_pc_plus4: got %h want 4", pc_plus4); else passCount++;
        checkCount++; if (instruction !== 32'h0) $display("[TB] FAIL reset_instr: got %h want 0", instruction); else passCount++;
        checkCount++; if (instr_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", instr_valid); else passCount++;
        checkCount++; if (fetch_fault !== 1'b0) $display("[TB] FAIL reset_fault: got %b want 0", fetch_fault); else passCount++;
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        step_t steps[$];
        logic [31:0] exp;
        steps.push_back('{2'b01, 64'h0, 64'h0, 64'h0, 0});
        steps.push_back('{2'b01, 64'h0, 64'h0, 64'h4, 3});
        foreach (steps[k]) begin
            applyStimulus(steps[k].nps, steps[k].npcin, steps[k].nconst);
            checkCount++; if (!obsSeen) $display("[TB] FAIL seq_valid[%0d]: no pulse within bound", k); else passCount++;
            checkCount++; if (obsAddr !== steps[k].expAddr) $display("[TB] FAIL seq_addr[%0d]: got %h want %h", k, obsAddr, steps[k].expAddr); else passCount++;
            checkCount++; if (obsPc !== steps[k].expAddr) $display("[TB] FAIL seq_pc[%0d]: got %h want %h", k, obsPc, steps[k].expAddr); else passCount++;
            checkCount++; if (obsPlus4 !== steps[k].expAddr + 64'h4) $display("[TB] FAIL seq_pc_plus4[%0d]: got %h want %h", k, obsPlus4, steps[k].expAddr + 64'h4); else passCount++;
            checkCount++;
            if (expQ.size() == 0) $display("[TB] FAIL seq_instr[%0d]: got %h want (no fetch recorded)", k, obsInstr);
            else begin
                exp = expQ.pop_front();
                if (obsInstr !== exp) $display("[TB] FAIL seq_instr[%0d]: got %h want %h", k, obsInstr, exp); else passCount++;
            end
            if (steps[k].expGap != 0) begin
                checkCount++; if (obsCycles != steps[k].expGap) $display("[TB] FAIL seq_gap[%0d]: got %0d want %0d", k, obsCycles, steps[k].expGap); else passCount++;
            end
        end
        checkCount++; if (obsInstr !== 32'h0 && steps.size() > 0 && expQ.size() != 0) $display("[TB] FAIL seq_queue_drained: got %0d want 0", expQ.size()); else passCount++;
    endtask

    task automatic test_wait_states();
        logic [31:0] exp;
        memDelay = 3;
        applyStimulus(2'b01, 64'h0, 64'h0);
        memDelay = 0;
        checkCount++; if (!obsSeen) $display("[TB] FAIL wait_valid: no pulse within bound"); else passCount++;
        checkCount++; if (obsReq != 4) $display("[TB] FAIL wait_req_cycles: got %0d want 4", obsReq); else passCount++;
        checkCount++; if (obsAddr !== 64'h8) $display("[TB] FAIL wait_addr: got %h want 8", obsAddr); else passCount++;
        checkCount++; if (obsAddrMoved) $display("[TB] FAIL wait_addr_stable: got moved want stable"); else passCount++;
        checkCount++; if (obsCycles != 6) $display("[TB] FAIL wait_gap: got %0d want 6", obsCycles); else passCount++;
        checkCount++; if (obsFault !== 1'b0) $display("[TB] FAIL wait_fault: got %b want 0", obsFault); else passCount++;
        checkCount++;
        if (expQ.size() != 1) $display("[TB] FAIL wait_single_fetch: got %0d want 1 queued", expQ.size());
        else begin
            exp = expQ.pop_front();
            if (obsInstr !== exp || exp !== memData(64'h8)) $display("[TB] FAIL wait_instr: got %h want %h", obsInstr, memData(64'h8)); else passCount++;
        end
    endtask

    task automatic test_branches();
        step_t steps[$];
        logic [31:0] exp;
        steps.push_back('{2'b01, 64'h0, 64'h0, 64'hC, 3});
        steps.push_back('{2'b11, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h10, 3});
        steps.push_back('{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h8, 3});
        steps.push_back('{2'b01, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 3});
        steps.push_back('{2'b10, 64'h1003, 64'h0, 64'h0, 3});
        steps.push_back('{2'b00, 64'h0, 64'h0, 64'h1000, 3});
        steps.push_back('{2'b01, 64'h0, 64'h0, 64'h1000, 3});
        foreach (steps[k]) begin
            applyStimulus(steps[k].nps, steps[k].npcin, steps[k].nconst);
            checkCount++; if (!obsSeen) $display("[TB] FAIL br_valid[%0d]: no pulse within bound", k); else passCount++;
            checkCount++; if (obsAddr !== steps[k].expAddr) $display("[TB] FAIL br_addr[%0d]: got %h want %h", k, obsAddr, steps[k].expAddr); else passCount++;
            checkCount++; if (obsPlus4 !== steps[k].expAddr + 64'h4) $display("[TB] FAIL br_pc_plus4[%0d]: got %h want %h", k, obsPlus4, steps[k].expAddr + 64'h4); else passCount++;
            checkCount++; if (obsCycles != steps[k].expGap) $display("[TB] FAIL br_gap[%0d]: got %0d want %0d", k, obsCycles, steps[k].expGap); else passCount++;
            checkCount++;
            if (expQ.size() == 0) $display("[TB] FAIL br_instr[%0d]: got %h want (no fetch recorded)", k, obsInstr);
            else begin
                exp = expQ.pop_front();
                if (obsInstr !== exp) $display("[TB] FAIL br_instr[%0d]: got %h want %h", k, obsInstr, exp); else passCount++;
            end
        end
    endtask

    task automatic test_timeout();
        int  reqCycles = 0;
        bit  faulted   = 1'b0;
        memEnable  = 1'b0;
        imem_ready = 1'b0;
        for (int i = 0; i < 40 && !faulted; i++) begin
            @(negedge clk);
            if (imem_req) reqCycles++;
            if (fetch_fault) faulted = 1'b1;
        end
        checkCount++; if (!faulted) $display("[TB] FAIL timeout_fault: got 0 want 1 within bound"); else passCount++;
        checkCount++; if (reqCycles != 15) $display("[TB] FAIL timeout_req_cycles: got %0d want 15", reqCycles); else passCount++;
        checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL timeout_req: got %b want 0", imem_req); else passCount++;
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        repeat (5) @(negedge clk);
        imem_ready = 1'b0;
        checkCount++; if (fetch_fault !== 1'b1) $display("[TB] FAIL timeout_sticky: got %b want 1", fetch_fault); else passCount++;
        checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL timeout_req_hold: got %b want 0", imem_req); else passCount++;
        checkCount++; if (pc !== 64'h1004) $display("[TB] FAIL timeout_pc_frozen: got %h want 1004", pc); else passCount++;
        checkCount++; if (instr_valid !== 1'b0) $display("[TB] FAIL timeout_no_issue: got %b want 0", instr_valid); else passCount++;
        #2 rst = 1'b1;
        #1;
        checkCount++; if (fetch_fault !== 1'b0) $display("[TB] FAIL timeout_rst_fault: got %b want 0", fetch_fault); else passCount++;
        checkCount++; if (pc !== 64'h0) $display("[TB] FAIL timeout_rst_pc: got %h want 0", pc); else passCount++;
        expQ.delete();
    endtask

    task automatic test_reset_mid_fetch();
        int          reqSeen = 0;
        logic [31:0] exp;
        @(negedge clk);
        rst       = 1'b0;
        memEnable = 1'b1;
        applyStimulus(2'b10, 64'h20, 64'h0);
        memEnable  = 1'b0;
        imem_ready = 1'b0;
        checkCount++; if (obsAddr !== 64'h0 || !obsSeen) $display("[TB] FAIL mid_first_addr: got %h want 0", obsAddr); else passCount++;
        void'(expQ.pop_front());
        for (int i = 0; i < 10 && reqSeen < 2; i++) begin
            @(negedge clk);
            if (imem_req) reqSeen++;
        end
        checkCount++; if (reqSeen != 2 || imem_addr !== 64'h20) $display("[TB] FAIL mid_fetch_addr: got %h want 20", imem_addr); else passCount++;
        #2 rst = 1'b1;
        #1;
        checkCount++; if (imem_req !== 1'b0) $display("[TB] FAIL mid_rst_req: got %b want 0", imem_req); else passCount++;
        checkCount++; if (pc !== 64'h0) $display("[TB] FAIL mid_rst_pc: got %h want 0", pc); else passCount++;
        checkCount++; if (imem_addr !== 64'h0) $display("[TB] FAIL mid_rst_addr: got %h want 0", imem_addr); else passCount++;
        @(negedge clk);
        imem_rdata = 32'hDEAD_BEEF;
        imem_ready = 1'b1;
        @(posedge clk);
        #1;
        checkCount++; if (instruction !== 32'h0) $display("[TB] FAIL mid_rst_ready_ignored: got %h want 0", instruction); else passCount++;
        @(negedge clk);
        imem_ready = 1'b0;
        rst        = 1'b0;
        memEnable  = 1'b1;
        applyStimulus(2'b01, 64'h0, 64'h0);
        checkCount++; if (!obsSeen || obsAddr !== 64'h0) $display("[TB] FAIL mid_refetch_addr: got %h want 0", obsAddr); else passCount++;
        checkCount++;
        if (expQ.size() == 0) $display("[TB] FAIL mid_refetch_instr: got %h want 91019004", obsInstr);
        else begin
            exp = expQ.pop_front();
            if (obsInstr !== 32'h91019004 || exp !== 32'h91019004) $display("[TB] FAIL mid_refetch_instr: got %h want 91019004", obsInstr); else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_branches();
        test_timeout();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch unit: the supplying end of the control unit's instruction interface.
- Owns the program counter and fetches 32-bit instructions from instruction memory over a req/ready handshake.
- Presents each instruction to the control unit, then waits for execution to finish.
- Consumes the PS field (controlWord[30:29]) and the constant to compute the next PC.

Parameters:
PC_WIDTH, 64, program counter / address width
RESET_PC, 0, PC value loaded on reset
TIMEOUT, 15, max FETCH cycles without imem_ready before fault

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
ps  input  2  PC select from controlWord[30:29]: 00 hold, 01 PC+4, 10 PC <- pc_in, 11 PC + (constant<<2)
pc_in  input  PC_WIDTH  register-sourced branch target (BR)
constant  input  64  signed word offset for relative branch
exec_done  input  1  control unit/datapath: current instruction complete, ps/pc_in/constant valid
imem_req  output  1  instruction memory read request
imem_addr  output  PC_WIDTH  read address
imem_rdata  input  32  read data, valid when imem_ready=1
imem_ready  input  1  read data valid this cycle
instruction  output  32  instruction to control unit
instr_valid  output  1  one-cycle pulse: new instruction presented
pc  output  PC_WIDTH  current PC
pc_plus4  output  PC_WIDTH  pc+4, combinational (link value for BL)
fetch_fault  output  1  sticky memory-timeout flag

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=IDLE.
  - instruction=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC, fetch_fault=0, wait counter=0.
- States:
  - IDLE -> FETCH, unconditionally, next cycle.
  - FETCH:
    - imem_req=1, imem_addr=pc.
    - imem_ready=1 at a rising edge: latch imem_rdata into instruction, clear counter, go ISSUE.
    - Otherwise counter++. When counter reaches TIMEOUT without ready: go FAULT.
  - ISSUE: instr_valid=1 for exactly this cycle, imem_req=0, go EXEC. exec_done is ignored here.
  - EXEC:
    - Wait for exec_done=1.
    - On that edge: pc updates per ps, go FETCH.
  - FAULT: imem_req=0, fetch_fault=1, pc frozen. Stays here until rst.
- Next-PC arithmetic, all modulo 2^PC_WIDTH (wraps silently):
  - 00: pc unchanged; the same instruction is re-fetched (used as halt/spin).
  - 01: pc+4.
  - 10: pc_in with bits [1:0] forced to 0.
  - 11: pc + (constant<<2), constant treated as two's complement.
- Latency:
  - Zero-wait memory: FETCH, ISSUE, EXEC = 3 cycles minimum per instruction (EXEC is 1 cycle if exec_done is already high).
  - Each memory wait cycle adds 1.
- instruction holds its value from the latch until the next successful fetch, including throughout EXEC.
- imem_addr changes only while imem_req=0, or on a transition into FETCH.
- imem_ready outside FETCH is ignored, as is a late ready after reset.
- exec_done held high across multiple cycles advances the PC only once per instruction, since it is sampled only in EXEC.
- Reset mid-FETCH: imem_req drops asynchronously and any in-flight read is discarded.

Test Plan:
- Reset then release, zero-wait memory returning 0x91019004 at address 0, exec_done=1, ps=01 -> imem_addr 0, 4, 8 on successive fetches; instr_valid pulses every 3 cycles; instruction=0x91019004 after the first fetch; pc_plus4=pc+4.
- imem_ready delayed 3 cycles at pc=0x8 -> imem_req high for 4 cycles; addr stable at 0x8; a single instr_valid pulse afterward; no fault.
- pc=0x10, ps=11, constant=-2 -> next fetch address 0x08. Also pc=0xFFFFFFFFFFFFFFFC, ps=01 -> wraps to 0x0.
- pc_in=0x1003, ps=10 -> next fetch address 0x1000. ps=00 -> same address re-fetched, with instr_valid pulsing again.
- imem_ready held 0 -> after TIMEOUT (15) FETCH cycles, fetch_fault=1 and imem_req=0. Both persist until rst, which clears them.
- Assert rst during the 2nd wait cycle of a fetch at pc=0x20 -> imem_req=0 and pc=RESET_PC immediately. A ready pulse arriving during reset does not update instruction.
